// File: rtl/score_pkg.sv
// Shared types and constants for the score accumulator: bus width, FSM states,
// game-mode codes and level codes.
package score_pkg;

  // Every score, combo and count bus has this width, including the ones inside the hit interface.
  localparam int SCORE_W = 21;

  typedef logic [SCORE_W-1:0] score_t;

  localparam score_t SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MOD_NORMAL  = 2'b00;
  localparam logic [1:0] MOD_NO_FAIL = 2'b01;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_FAIL = 3'd6;

endpackage

// File: rtl/score_accumulator_if.sv
// Hit bus between the per-note scoring stage (master) and the score accumulator
// (slave), including the registered values fed back to break the combinational loop.
interface score_accumulator_if;
  import score_pkg::*;

  logic               hit_valid;
  score_t             base_score;
  score_t             bonus_score;
  score_t             combo;
  logic [LEVEL_W-1:0] level;

  score_t             last_combo;
  score_t             last_base_score;
  score_t             now_cnt;

  modport master (
    output hit_valid, base_score, bonus_score, combo, level,
    input  last_combo, last_base_score, now_cnt
  );

  modport slave (
    input  hit_valid, base_score, bonus_score, combo, level,
    output last_combo, last_base_score, now_cnt
  );

endinterface

// File: rtl/score_accumulator_sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping.
module sat_add
  import score_pkg::*;
#(
  parameter int W = SCORE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[W] ? '1 : full[W-1:0];

endmodule

// File: rtl/score_accumulator.sv
// Per-song score accumulator with IDLE/PLAY/DONE sequencing and saturating totals.
// Health tracking and failure-ending are built only when SCORE_FAIL_DETECT_EN is defined.
module score_accumulator
  import score_pkg::*;
#(
  parameter int HP_MAX  = 200,
  parameter int HP_MISS = 20,
  parameter int HP_GAIN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  score_t              total_note,
  input  logic [1:0]          mod,
  score_accumulator_if.slave  hit_if,
  output score_t              total_score,
  output score_t              max_combo,
  output logic [LEVEL_W-1:0]  final_level,
  output logic                playing,
  output logic                done,
  output logic                failed,
  output logic [7:0]          health
);

  localparam logic [7:0] HP_MAX_8 = 8'(HP_MAX);

  state_e             state_q, state_d;
  score_t             last_combo_q, last_combo_d;
  score_t             last_base_q, last_base_d;
  score_t             now_cnt_q, now_cnt_d;
  score_t             total_score_q, total_score_d;
  score_t             max_combo_q, max_combo_d;
  score_t             total_note_q, total_note_d;
  logic [LEVEL_W-1:0] final_level_q, final_level_d;

`ifdef SCORE_FAIL_DETECT_EN
  localparam logic [7:0] HP_MISS_8 = 8'(HP_MISS);
  localparam logic [7:0] HP_GAIN_8 = 8'(HP_GAIN);

  logic [1:0] mod_q, mod_d;
  logic [7:0] health_q, health_d;
  logic       failed_q, failed_d;
`else
  logic unused_mod;
  assign unused_mod = ^mod;
`endif

  score_t base_sum, hit_pts, total_sum, cnt_sum;

  sat_add u_base_acc  (.a(last_base_q),        .b(hit_if.base_score),  .sum(base_sum));
  sat_add u_hit_sum   (.a(hit_if.base_score),  .b(hit_if.bonus_score), .sum(hit_pts));
  sat_add u_total_acc (.a(total_score_q),      .b(hit_pts),            .sum(total_sum));
  sat_add u_cnt_acc   (.a(now_cnt_q),          .b(score_t'(1)),        .sum(cnt_sum));

  always_comb begin
    // NOTE: every _d starts as its _q, so any path that does not assign it holds the flop rather than inferring a latch.
    state_d       = state_q;
    last_combo_d  = last_combo_q;
    last_base_d   = last_base_q;
    now_cnt_d     = now_cnt_q;
    total_score_d = total_score_q;
    max_combo_d   = max_combo_q;
    total_note_d  = total_note_q;
    final_level_d = final_level_q;
`ifdef SCORE_FAIL_DETECT_EN
    mod_d         = mod_q;
    health_d      = health_q;
    failed_d      = failed_q;
`endif

    if (abort) begin
      state_d = S_IDLE;
    end else if (start) begin
      last_combo_d  = '0;
      last_base_d   = '0;
      now_cnt_d     = '0;
      total_score_d = '0;
      max_combo_d   = '0;
      total_note_d  = total_note;
      // An empty chart has nothing to play and finishes immediately.
      if (total_note == '0) begin
        state_d       = S_DONE;
        final_level_d = hit_if.level;
      end else begin
        state_d = S_PLAY;
      end
`ifdef SCORE_FAIL_DETECT_EN
      mod_d    = mod;
      health_d = HP_MAX_8;
      failed_d = 1'b0;
`endif
    end else if (state_q == S_PLAY && hit_if.hit_valid) begin
      last_combo_d  = hit_if.combo;
      last_base_d   = base_sum;
      total_score_d = total_sum;
      now_cnt_d     = cnt_sum;
      if (hit_if.combo > max_combo_q) max_combo_d = hit_if.combo;

      if (cnt_sum == total_note_q) begin
        state_d       = S_DONE;
        final_level_d = hit_if.level;
      end

`ifdef SCORE_FAIL_DETECT_EN
      if (hit_if.base_score == '0)
        health_d = (health_q <= HP_MISS_8) ? 8'd0 : health_q - HP_MISS_8;
      else
        health_d = (health_q >= HP_MAX_8 - HP_GAIN_8) ? HP_MAX_8 : health_q + HP_GAIN_8;

      // Depletion overrides a simultaneous chart completion and forces the fail level.
      if (health_d == 8'd0 && mod_q != MOD_NO_FAIL) begin
        state_d       = S_DONE;
        failed_d      = 1'b1;
        final_level_d = LEVEL_FAIL;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_combo_q  <= '0;
      last_base_q   <= '0;
      now_cnt_q     <= '0;
      total_score_q <= '0;
      max_combo_q   <= '0;
      total_note_q  <= '0;
      final_level_q <= LEVEL_FAIL;
`ifdef SCORE_FAIL_DETECT_EN
      mod_q         <= MOD_NORMAL;
      health_q      <= HP_MAX_8;
      failed_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
      state_q       <= state_d;
      last_combo_q  <= last_combo_d;
      last_base_q   <= last_base_d;
      now_cnt_q     <= now_cnt_d;
      total_score_q <= total_score_d;
      max_combo_q   <= max_combo_d;
      total_note_q  <= total_note_d;
      final_level_q <= final_level_d;
`ifdef SCORE_FAIL_DETECT_EN
      mod_q         <= mod_d;
      health_q      <= health_d;
      failed_q      <= failed_d;
`endif
    end
  end

  assign hit_if.last_combo      = last_combo_q;
  assign hit_if.last_base_score = last_base_q;
  assign hit_if.now_cnt         = now_cnt_q;
  assign total_score            = total_score_q;
  assign max_combo              = max_combo_q;
  assign final_level            = final_level_q;
  assign playing                = (state_q == S_PLAY);
  assign done                   = (state_q == S_DONE);

`ifdef SCORE_FAIL_DETECT_EN
  assign health = health_q;
  assign failed = failed_q;
`else
  assign health = HP_MAX_8;
  assign failed = 1'b0;
`endif

endmodule
